corr_best_match: RTL and testbench
==================================

# corr_best_match

Sweep controller and peak tracker that sits directly around the correlation scorer. It steps candidate window origins across the frame in raster order and issues one correlation per origin. It collects each returned 32-bit score and reports the origin with the highest score. Its output feeds the tracking/overlay logic with a single best-match coordinate per frame search.

## Interface
Parameters:
- FRAME_H_RES, 640, frame width in pixels
- FRAME_V_RES, 480, frame height in pixels
- WIN_H, 64, correlation window width; the last valid x origin is ≤ FRAME_H_RES−WIN_H
- WIN_V, 48, correlation window height; the last valid y origin is ≤ FRAME_V_RES−WIN_V
- STEP, 4, origin increment in both axes (≥1)
- TIMEOUT, 65535, watchdog limit in cycles (used only with the macro)

Ports (one clock, iCLK; reset iRST_N is asynchronous, active-low):
- iCLK  in  1  system clock, 50 MHz
- iRST_N  in  1  asynchronous active-low reset
- iStart  in  1  one-cycle pulse that begins a full sweep
- oCorrStart  out  1  one-cycle pulse to the scorer; oXstart/oYstart are valid on this cycle
- oXstart  out  13  candidate origin x
- oYstart  out  13  candidate origin y
- iCorrDone  in  1  scorer completion pulse
- iScore  in  32  scorer result, sampled when iCorrDone=1
- oBusy  out  1  high from the cycle after an accepted iStart until DONE
- oDone  out  1  level signal; high in DONE until the next accepted iStart
- oBestX  out  13  x origin of the best score
- oBestY  out  13  y origin of the best score
- oBestScore  out  32  best score
- oTimeouts  out  8  count of timed-out candidates (saturating at 255); tied to 0 when the macro is absent

## Operation
- States: IDLE, ISSUE, WAIT, UPDATE, ADVANCE, DONE.
- IDLE/DONE, iStart=1: clear x/y to 0; clear best score to 0; clear best origin to (0,0); clear oTimeouts; go to ISSUE.
- ISSUE: assert oCorrStart for exactly 1 cycle; go to WAIT.
- WAIT: hold oXstart/oYstart stable. On iCorrDone, latch iScore and go to UPDATE.
- UPDATE: if the latched score is strictly greater than oBestScore, or this is the first candidate, update the best triple. On a tie, the earlier raster-order origin is kept.
- ADVANCE, x direction: if x+STEP ≤ FRAME_H_RES−WIN_H, then x += STEP and go to ISSUE.
- ADVANCE, y direction: else if y+STEP ≤ FRAME_V_RES−WIN_V, then x=0, y += STEP, go to ISSUE.
- ADVANCE, end of sweep: else go to DONE.
- Candidate counts: ⌊(FRAME_H_RES−WIN_H)/STEP⌋+1 per row, ⌊(FRAME_V_RES−WIN_V)/STEP⌋+1 rows.
- The x+STEP comparison is computed at 14 bits, so there is no 13-bit wrap.
- iStart in ISSUE/WAIT/UPDATE/ADVANCE is ignored.
- iCorrDone outside WAIT is ignored.
- iCorrDone arriving in the same cycle as the ISSUE pulse is ignored; WAIT starts on the next cycle.
- Asynchronous reset, including mid-sweep, sets the state to IDLE and every output to 0: oCorrStart, oXstart, oYstart, oBusy, oDone, oBest*, oTimeouts.

## Timing
- iStart at cycle 0 → ISSUE at 1; oCorrStart high at 1; oBusy high from 1.
- iCorrDone at cycle n → UPDATE at n+1, ADVANCE at n+2, next oCorrStart at n+3.
- Overhead is 4 cycles per candidate plus scorer latency.
- The best triple updates at the clock edge that ends UPDATE.
- After the final ADVANCE: oDone=1, oBusy=0 on the same cycle.
- oBest* stay stable while oDone=1.

## Configuration
- CORR_TIMEOUT_EN defined: a watchdog counts cycles in WAIT.
  - At TIMEOUT cycles without iCorrDone, the candidate is abandoned.
  - The best triple is not updated for that candidate.
  - oTimeouts increments (saturating) and the state goes to ADVANCE.
- CORR_TIMEOUT_EN undefined: WAIT waits indefinitely; oTimeouts is constant 0.

## Test plan
Bench parameters: FRAME 16×12, WIN 8×8, STEP 4. This gives origins x∈{0,4,8}, y∈{0,4}, 6 candidates.
- Scorer model returning score = 100 + 10·(candidate index), latency 5 → 6 oCorrStart pulses at origins (0,0),(4,0),(8,0),(0,4),(4,4),(8,4); final oBest=(8,4,150); oDone=1.
- All scores equal 77 → oBest=(0,0,77); tie keeps the first origin.
- Scores with a peak of 0xFFFF_FFFF at (4,0), all others 0 → oBestX=4, oBestY=0, oBestScore=0xFFFF_FFFF.
- iStart pulsed during WAIT, plus a spurious iCorrDone during UPDATE → neither is accepted; the sequence and results match the first scenario.
- iRST_N low during the 3rd WAIT → all outputs 0 asynchronously; after release and a new iStart, the sweep restarts at (0,0).
- With CORR_TIMEOUT_EN and TIMEOUT=20, the scorer never answers at (4,4) → that candidate is skipped after 20 cycles; oTimeouts=1; other origins are scored normally; the sweep completes.

Source files
------------

// File: rtl/corr_best_match_if.sv
// corr_best_match_if: bundles the sweep-control and scorer handshake signals
// of corr_best_match. The master modport is the sweep controller; the slave
// modport is its environment (the start source and the correlation scorer).
interface corr_best_match_if;
    logic        iStart;
    logic        oCorrStart;
    logic [12:0] oXstart;
    logic [12:0] oYstart;
    logic        iCorrDone;
    logic [31:0] iScore;
    logic        oBusy;
    logic        oDone;
    logic [12:0] oBestX;
    logic [12:0] oBestY;
    logic [31:0] oBestScore;
    logic [7:0]  oTimeouts;

    modport master (
        input  iStart, iCorrDone, iScore,
        output oCorrStart, oXstart, oYstart, oBusy, oDone,
               oBestX, oBestY, oBestScore, oTimeouts
    );

    modport slave (
        output iStart, iCorrDone, iScore,
        input  oCorrStart, oXstart, oYstart, oBusy, oDone,
               oBestX, oBestY, oBestScore, oTimeouts
    );
endinterface

// File: rtl/corr_best_match.sv
// corr_best_match: raster sweep of correlation window origins with peak tracking.
// Steps (x,y) across the frame by STEP, fires one scorer request per origin,
// and keeps the origin with the strictly highest score (ties keep the earlier
// origin in raster order).
//
// Optional feature macro: CORR_TIMEOUT_EN
//   defined   - a WAIT watchdog abandons a candidate after TIMEOUT cycles and
//               counts it in oTimeouts (saturating at 255)
//   undefined - WAIT waits indefinitely and oTimeouts is constant 0
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for iStart
// ISSUE   | oCorrStart high for this single cycle, origin valid
// WAIT    | origin held, waiting for iCorrDone (or watchdog expiry)
// UPDATE  | compare latched score against the running best
// ADVANCE | step to next origin in raster order, or finish
// DONE    | results stable, oDone high, waiting for next iStart
module corr_best_match #(
    parameter int FRAME_H_RES = 640,
    parameter int FRAME_V_RES = 480,
    parameter int WIN_H       = 64,
    parameter int WIN_V       = 48,
    parameter int STEP        = 4,
    parameter int TIMEOUT     = 65535
) (
    input logic               iCLK,
    input logic               iRST_N,
    corr_best_match_if.master bus
);

    // Last valid origins and the step, all at 14 bits so x+STEP cannot wrap.
    localparam logic [13:0] X_LAST = 14'(FRAME_H_RES - WIN_H);
    localparam logic [13:0] Y_LAST = 14'(FRAME_V_RES - WIN_V);
    localparam logic [13:0] STEP_W = 14'(STEP);

    if (STEP < 1 || TIMEOUT < 1) begin : g_param_check
        $error("corr_best_match: STEP and TIMEOUT must both be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        UPDATE  = 3'd3,
        ADVANCE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t      state;
    logic [12:0] x_pos;
    logic [12:0] y_pos;
    logic        corr_start;
    logic        busy;
    logic        done;
    logic [12:0] best_x;
    logic [12:0] best_y;
    logic [31:0] best_score;
    logic [31:0] score_q;
    logic        first_cand;
    logic [7:0]  timeouts;
    logic [13:0] x_step;
    logic [13:0] y_step;

`ifdef CORR_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    // Candidate next origins, widened by one bit for the bound compare.
    always_comb begin
        x_step = {1'b0, x_pos} + STEP_W;
        y_step = {1'b0, y_pos} + STEP_W;
    end

    // Sweep FSM with registered outputs and running-best tracking.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            x_pos      <= '0;
            y_pos      <= '0;
            corr_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            best_x     <= '0;
            best_y     <= '0;
            best_score <= '0;
            score_q    <= '0;
            first_cand <= 1'b0;
            timeouts   <= '0;
`ifdef CORR_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            corr_start <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.iStart) begin
                        x_pos      <= '0;
                        y_pos      <= '0;
                        best_x     <= '0;
                        best_y     <= '0;
                        best_score <= '0;
                        first_cand <= 1'b1;
                        timeouts   <= '0;
                        corr_start <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A done pulse coincident with the request is not a reply.
`ifdef CORR_TIMEOUT_EN
                    wd_cnt <= WD_W'(TIMEOUT - 1);
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.iCorrDone) begin
                        score_q <= bus.iScore;
                        state   <= UPDATE;
                    end
`ifdef CORR_TIMEOUT_EN
                    else if (wd_cnt == '0) begin
                        if (timeouts != 8'hFF) begin
                            timeouts <= timeouts + 8'd1;
                        end
                        state <= ADVANCE;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
`endif
                end
                UPDATE: begin
                    // First scored candidate always wins so a best of 0 is real.
                    if (first_cand || (score_q > best_score)) begin
                        best_x     <= x_pos;
                        best_y     <= y_pos;
                        best_score <= score_q;
                        first_cand <= 1'b0;
                    end
                    state <= ADVANCE;
                end
                ADVANCE: begin
                    if (x_step <= X_LAST) begin
                        x_pos      <= x_step[12:0];
                        corr_start <= 1'b1;
                        state      <= ISSUE;
                    end else if (y_step <= Y_LAST) begin
                        x_pos      <= '0;
                        y_pos      <= y_step[12:0];
                        corr_start <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.oCorrStart = corr_start;
    assign bus.oXstart    = x_pos;
    assign bus.oYstart    = y_pos;
    assign bus.oBusy      = busy;
    assign bus.oDone      = done;
    assign bus.oBestX     = best_x;
    assign bus.oBestY     = best_y;
    assign bus.oBestScore = best_score;
    assign bus.oTimeouts  = timeouts;

endmodule

// File: tb/tb_corr_best_match.sv
// tb_corr_best_match: directed bench for corr_best_match on a 16x12 frame,
// 8x8 window, STEP 4 (origins x in {0,4,8}, y in {0,4}; 6 candidates).
module tb_corr_best_match;

    logic iCLK;
    logic iRST_N;
    int   n_cmp;
    int   n_bad;

    corr_best_match_if bus ();

    corr_best_match #(
        .FRAME_H_RES(16),
        .FRAME_V_RES(12),
        .WIN_H      (8),
        .WIN_V      (8),
        .STEP       (4),
        .TIMEOUT    (20)
    ) dut (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .bus   (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0/4: 100+10k, 1: all 77, 2: peak at k=1, 3: as 0 with spurious inputs
    function automatic logic [31:0] score_of(input int mode, input int k);
        case (mode)
            1:       return 32'd77;
            2:       return (k == 1) ? 32'hFFFF_FFFF : 32'd0;
            default: return 32'(100 + 10 * k);
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_corr_start"}, 32'(bus.oCorrStart), 32'd0);
        chk({tag, "_xstart"},     32'(bus.oXstart),    32'd0);
        chk({tag, "_ystart"},     32'(bus.oYstart),    32'd0);
        chk({tag, "_busy"},       32'(bus.oBusy),      32'd0);
        chk({tag, "_done"},       32'(bus.oDone),      32'd0);
        chk({tag, "_best_x"},     32'(bus.oBestX),     32'd0);
        chk({tag, "_best_y"},     32'(bus.oBestY),     32'd0);
        chk({tag, "_best_score"}, bus.oBestScore,      32'd0);
        chk({tag, "_timeouts"},   32'(bus.oTimeouts),  32'd0);
    endtask

    // mode 5 pulls reset during the third WAIT and returns early.
    task automatic run_sweep(input int mode, input int skip_k,
                             input logic [12:0] ex_bx, input logic [12:0] ex_by,
                             input logic [31:0] ex_bs, input logic [7:0] ex_to);
        int cnt;
        int gap_exp;
        logic [12:0] ex_x;
        logic [12:0] ex_y;
        gap_exp = 2;
        @(negedge iCLK);
        bus.iStart = 1'b1;
        @(negedge iCLK);
        bus.iStart = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ex_x = 13'((k % 3) * 4);
            ex_y = 13'((k / 3) * 4);
            cnt = 0;
            while (bus.oCorrStart !== 1'b1 && cnt < 100) begin
                @(negedge iCLK);
                cnt++;
            end
            chk("corr_start_seen", 32'(bus.oCorrStart), 32'd1);
            if (k > 0 && mode != 3) chk("issue_gap", 32'(cnt), 32'(gap_exp));
            chk("xstart", 32'(bus.oXstart), 32'(ex_x));
            chk("ystart", 32'(bus.oYstart), 32'(ex_y));
            chk("busy_sweep", 32'(bus.oBusy), 32'd1);
            @(negedge iCLK);
            chk("corr_start_one_cycle", 32'(bus.oCorrStart), 32'd0);
            if (mode == 5 && k == 2) begin
                iRST_N = 1'b0;
                #1;
                check_all_zero("reset_mid");
                @(negedge iCLK);
                iRST_N = 1'b1;
                return;
            end
            if (k == skip_k) begin
                gap_exp = 21;
            end else begin
                gap_exp = 2;
                for (int j = 2; j <= 5; j++) begin
                    @(negedge iCLK);
                    if (mode == 3 && j == 2) bus.iStart = 1'b1;
                    if (mode == 3 && j == 3) bus.iStart = 1'b0;
                end
                chk("xstart_hold", 32'(bus.oXstart), 32'(ex_x));
                bus.iCorrDone = 1'b1;
                bus.iScore    = score_of(mode, k);
                @(negedge iCLK);
                bus.iCorrDone = 1'b0;
                bus.iScore    = 32'd0;
                if (mode == 3) begin
                    bus.iCorrDone = 1'b1;
                    bus.iScore    = 32'hFFFF_FFFF;
                    @(negedge iCLK);
                    bus.iCorrDone = 1'b0;
                    bus.iScore    = 32'd0;
                end
            end
        end
        cnt = 0;
        while (bus.oDone !== 1'b1 && cnt < 100) begin
            @(negedge iCLK);
            cnt++;
        end
        chk("done", 32'(bus.oDone), 32'd1);
        chk("busy_done", 32'(bus.oBusy), 32'd0);
        chk("best_x", 32'(bus.oBestX), 32'(ex_bx));
        chk("best_y", 32'(bus.oBestY), 32'(ex_by));
        chk("best_score", bus.oBestScore, ex_bs);
        chk("timeouts", 32'(bus.oTimeouts), 32'(ex_to));
        repeat (3) @(negedge iCLK);
        chk("done_hold", 32'(bus.oDone), 32'd1);
        chk("best_score_hold", bus.oBestScore, ex_bs);
        chk("corr_start_idle", 32'(bus.oCorrStart), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        iRST_N        = 1'b0;
        bus.iStart    = 1'b0;
        bus.iCorrDone = 1'b0;
        bus.iScore    = 32'd0;
        repeat (2) @(negedge iCLK);
        check_all_zero("reset");
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);
        check_all_zero("idle");

        // Rising scores: last origin (8,4) wins with 150.
        run_sweep(0, -1, 13'd8, 13'd4, 32'd150, 8'd0);
        // All equal: tie keeps (0,0).
        run_sweep(1, -1, 13'd0, 13'd0, 32'd77, 8'd0);
        // Single maximal peak at (4,0).
        run_sweep(2, -1, 13'd4, 13'd0, 32'hFFFF_FFFF, 8'd0);
        // Stray iStart in WAIT and iCorrDone in UPDATE are ignored.
        run_sweep(3, -1, 13'd8, 13'd4, 32'd150, 8'd0);
        // Reset during third WAIT, then a clean restart from (0,0).
        run_sweep(5, -1, 13'd0, 13'd0, 32'd0, 8'd0);
        repeat (2) @(negedge iCLK);
        check_all_zero("after_reset");
        run_sweep(0, -1, 13'd8, 13'd4, 32'd150, 8'd0);
`ifdef CORR_TIMEOUT_EN
        // Scorer silent at (4,4): skipped after 20 WAIT cycles.
        run_sweep(4, 4, 13'd8, 13'd4, 32'd150, 8'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
